uwb_data_writer: RTL and testbench
==================================

# uwb_data_writer

Transmit-side counterpart of the UWB receive path. Accepts a byte stream from the scan-data source, stages it in a small on-chip buffer, polls the UWB module for TX-buffer usage over the byte-wide SPI master link, and pushes staged bytes into the UWB module with burst-write transfers. Sits between the microscope data packer and the `SPI_master` instance on the transmitter board, on the `clk` (3 MHz byte-rate) domain.

## Interface
- `BUF_DEPTH`, 255: UWB TX-buffer capacity, bytes.
- `MAX_BURST`, 64: maximum payload bytes per burst write. Also the stage FIFO depth. Must be 1..254.
- `SPI_LAT`, 2: cycles from driving a byte on `to_spi` to its response on `from_spi`.
- `clk` in 1: byte-rate clock, shared with `SPI_master` byte strobe.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: 0 stops new polls; any transfer in progress completes.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: stage FIFO not full; a byte transfers when `in_valid && in_ready` at the rising edge of `clk`.
- `to_spi` out 8: byte to `SPI_master`, one per cycle; 0 when idle.
- `from_spi` in 8: byte returned by `SPI_master`.
- `busy` out 1: an SPI transfer is in progress (from the LEN cycle through the last byte).

## Operation
- Transfer framing: a length byte L is followed by exactly L bytes on consecutive cycles. Outside a transfer, `to_spi` = 0.
- FSM states and actions:
  - IDLE: `to_spi` = 0. Go to P_LEN when `en` and stage count ≥ 1.
  - P_LEN: `to_spi` = 2.
  - P_CMD: `to_spi` = 3 (read TX usage).
  - P_DUM: `to_spi` = 0.
  - WAIT: `to_spi` = 0, held SPI_LAT−1 cycles.
  - CAP: register `usage = from_spi`. This is the response to P_DUM.
  - CALC: n = min(stage count, MAX_BURST, BUF_DEPTH − usage), saturating at 0 if usage > BUF_DEPTH. If n = 0, go to IDLE; else go to B_LEN.
  - B_LEN: `to_spi` = n+1.
  - B_CMD: `to_spi` = 63 (burst write, bit 7 clear).
  - DATA: n cycles. Each cycle pops one stage byte onto `to_spi`.
  - After DATA, return to IDLE.
- n is latched in CALC. Bytes arriving during DATA never enlarge the current burst.
- The stage FIFO is guaranteed to hold ≥ n bytes throughout DATA. A pop never underflows, and DATA is never stalled.
- Width rules: n+1 ≤ 255, so all arithmetic is 8-bit. `usage` is compared unsigned.
- Simultaneous push and pop in DATA is permitted. The stage count is unchanged in that case.
- Reset, including mid-transfer:
  - FSM returns to IDLE; stage FIFO is emptied; latched n and usage are cleared.
  - `to_spi` = 0, `busy` = 0.
  - `in_ready` = 0 during the reset cycle, then 1.

## Timing
- Poll transfer: 4 cycles (P_LEN..P_DUM). Decision follows SPI_LAT+1 cycles later.
- Minimum IDLE→first data byte: 4 + (SPI_LAT−1) + 2 + 2 = 9 cycles at default parameters.
- Full burst at default parameters: 9 + 64 = 73 cycles. Sustained throughput is ≥ 64/74 bytes per cycle when the UWB buffer drains.
- `in_ready` is a registered full flag. It deasserts the cycle after the FIFO holds MAX_BURST bytes with no pop.
- Data byte k of a burst appears on `to_spi` exactly k cycles after B_CMD.

## Configuration
- `UWB_WRITER_HEADER_EN` defined:
  - Each burst's first DATA byte is an 8-bit sequence number. It increments by 1 per burst and wraps 255→0; reset value 0.
  - n counts the header: payload = n−1, and the CALC minimum becomes min(count+1, …).
  - A burst with 0 payload is never sent; CALC treats n < 2 as 0.
- Not defined: DATA carries payload only, with no sequence counter logic.

## Structure
- Shared package `uwb_pkg`:
  - command constants `UWB_CMD_TX_USAGE` = 3 and `UWB_CMD_BURST_WR` = 63;
  - the `UWB_CMD_RD_FLAG` = 128 constant already used by the reader;
  - the FSM state enum.
- One sub-module, `uwb_stage_fifo`:
  - synchronous FIFO, depth MAX_BURST;
  - exposes push/pop, data, count, full;
  - provides first-word fall-through on pop data.

## Test plan
- Reset, then push 10 bytes (0x10..0x19) with from_spi usage = 0:
  - `to_spi` sequence is 2, 3, 0, 0, then 11, 63, 0x10..0x19, then back to 0;
  - `busy` falls after 0x19.
- Push 100 bytes with usage = 0 → first burst n = 64 (L = 65), second burst L = 37 carrying bytes 65..100 in order.
- Stage 20 bytes with usage = 250 → burst L = 6 carrying 5 bytes. Next poll returns usage = 255 → n = 0, back to IDLE, no burst.
- Hold `in_valid` = 1 continuously through DATA → no byte lost or duplicated; `in_ready` never drops while count < 64.
- Assert `rst` during the 30th DATA cycle of a 64-byte burst → next cycle `to_spi` = 0, `busy` = 0, stage count 0; the next push restarts with a poll.
- With `UWB_WRITER_HEADER_EN`, three 4-byte bursts → L = 6 each, first DATA bytes 0, 1, 2.

Source files
------------

// File: rtl/uwb_pkg.sv
// rtl/uwb_pkg.sv - shared UWB command constants and writer FSM state type
package uwb_pkg;

    // Read flag on command bytes, shared with the receive-side reader.
    localparam logic [7:0] UWB_CMD_RD_FLAG  = 8'd128;
    // Query TX-buffer usage.
    localparam logic [7:0] UWB_CMD_TX_USAGE = 8'd3;
    // Burst write into the TX buffer (read flag clear).
    localparam logic [7:0] UWB_CMD_BURST_WR = 8'd63;
    // Length byte of a usage poll: command plus one dummy byte.
    localparam logic [7:0] UWB_POLL_LEN     = 8'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_P_LEN,
        ST_P_CMD,
        ST_P_DUM,
        ST_WAIT,
        ST_CAP,
        ST_CALC,
        ST_B_LEN,
        ST_B_CMD,
        ST_DATA
    } uwb_wr_state_e;

    function automatic logic [7:0] uwb_min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/uwb_stage_fifo.sv
// rtl/uwb_stage_fifo.sv - byte staging FIFO with first-word fall-through read
//
// Ports:
//   clk, rst        byte-rate clock, synchronous active-high reset
//   push, push_data write one byte (caller guarantees not full)
//   pop             remove the head byte (caller guarantees not empty)
//   pop_data        current head byte, valid whenever count != 0
//   count           bytes held, 0..DEPTH
//   full            registered: count == DEPTH
module uwb_stage_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic [7:0] count,
    output logic       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    count_q, count_d;
    logic          full_q, full_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + {7'd0, push} - {7'd0, pop};
        full_d   = (count_d == 8'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 8'd0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;

endmodule

// File: rtl/uwb_data_writer.sv
// rtl/uwb_data_writer.sv - stages a byte stream and burst-writes it into the UWB TX buffer over SPI
//
// Optional feature macro: UWB_WRITER_HEADER_EN (prefix each burst with a sequence byte).
//
// Ports:
//   clk, rst            byte-rate clock, synchronous active-high reset
//   en                  allow new usage polls; a running transfer always completes
//   in_data, in_valid   input byte stream
//   in_ready            stage FIFO can accept a byte
//   to_spi              byte to SPI master each cycle, 0 outside a transfer
//   from_spi            byte returned by SPI master, SPI_LAT cycles after to_spi
//   busy                poll or burst sequence in progress
module uwb_data_writer
    import uwb_pkg::*;
#(
    parameter int BUF_DEPTH = 255,
    parameter int MAX_BURST = 64,
    parameter int SPI_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] to_spi,
    input  logic [7:0] from_spi,
    output logic       busy
);

    localparam logic [7:0] BUF_DEPTH_B = 8'(BUF_DEPTH);
    localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);
    // WAIT runs SPI_LAT-1 cycles; the counter counts down to 0.
    localparam logic [7:0] WAIT_INIT   = 8'(SPI_LAT - 2);

    uwb_wr_state_e state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic [7:0]    usage_q, usage_d;
    logic [7:0]    n_q, n_d;
    logic [7:0]    idx_q, idx_d;

    logic          fifo_push, fifo_pop, fifo_full;
    logic [7:0]    fifo_head, fifo_count;

    logic [7:0]    space, avail, n_calc;
    logic [7:0]    to_spi_c;

`ifdef UWB_WRITER_HEADER_EN
    logic [7:0]    seq_q, seq_d;
`endif

    assign in_ready  = ~fifo_full & ~rst;
    assign fifo_push = in_valid & in_ready;

    uwb_stage_fifo #(
        .DEPTH (MAX_BURST)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // Burst size: bounded by staged bytes, the burst limit and free space in
    // the UWB buffer; a usage reading above capacity means no space at all.
    always_comb begin
        space  = (usage_q > BUF_DEPTH_B) ? 8'd0 : BUF_DEPTH_B - usage_q;
`ifdef UWB_WRITER_HEADER_EN
        avail  = fifo_count + 8'd1;
`else
        avail  = fifo_count;
`endif
        n_calc = uwb_min8(uwb_min8(avail, MAX_BURST_B), space);
`ifdef UWB_WRITER_HEADER_EN
        // A header with no payload behind it is not worth a transfer.
        if (n_calc < 8'd2) begin
            n_calc = 8'd0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        usage_d  = usage_q;
        n_d      = n_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        to_spi_c = 8'd0;
`ifdef UWB_WRITER_HEADER_EN
        seq_d    = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en && (fifo_count != 8'd0)) begin
                    state_d = ST_P_LEN;
                end
            end
            ST_P_LEN: begin
                to_spi_c = UWB_POLL_LEN;
                state_d  = ST_P_CMD;
            end
            ST_P_CMD: begin
                to_spi_c = UWB_CMD_TX_USAGE;
                state_d  = ST_P_DUM;
            end
            ST_P_DUM: begin
                if (SPI_LAT > 1) begin
                    wait_d  = WAIT_INIT;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CAP;
                end
            end
            ST_WAIT: begin
                if (wait_q == 8'd0) begin
                    state_d = ST_CAP;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_CAP: begin
                // This cycle's from_spi is the reply to the dummy byte.
                usage_d = from_spi;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                n_d     = n_calc;
                state_d = (n_calc == 8'd0) ? ST_IDLE : ST_B_LEN;
            end
            ST_B_LEN: begin
                to_spi_c = n_q + 8'd1;
                state_d  = ST_B_CMD;
            end
            ST_B_CMD: begin
                to_spi_c = UWB_CMD_BURST_WR;
                idx_d    = 8'd0;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                to_spi_c = fifo_head;
                fifo_pop = 1'b1;
`ifdef UWB_WRITER_HEADER_EN
                if (idx_q == 8'd0) begin
                    to_spi_c = seq_q;
                    fifo_pop = 1'b0;
                end
`endif
                idx_d = idx_q + 8'd1;
                if (idx_q == n_q - 8'd1) begin
                    state_d = ST_IDLE;
`ifdef UWB_WRITER_HEADER_EN
                    seq_d   = seq_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 8'd0;
            usage_q <= 8'd0;
            n_q     <= 8'd0;
            idx_q   <= 8'd0;
`ifdef UWB_WRITER_HEADER_EN
            seq_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            usage_q <= usage_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
`ifdef UWB_WRITER_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign to_spi = to_spi_c;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uwb_data_writer.sv
// tb/tb_uwb_data_writer.sv - self-checking bench for uwb_data_writer
module tb_uwb_data_writer;

    localparam int MAX_BURST = 64;
    localparam int SPI_LAT   = 2;
`ifdef UWB_WRITER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef logic [7:0] byte_q_t [$];

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] to_spi;
    logic [7:0] from_spi;
    logic       busy;

    int         n_tests;
    int         n_fail;
    int         cyc;
    int         mdl_cnt;
    logic       pop_pend;
    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] exp_seq;

    logic       in_frame;
    logic       f_is_poll;
    int         f_len;
    int         f_idx;
    logic [7:0] f_first;
    int         f_start;
    int         poll_start_cyc;
    int         burst_start_cyc;
    int         poll_cnt;
    int         data_seen;

    uwb_data_writer #(
        .BUF_DEPTH (255),
        .MAX_BURST (MAX_BURST),
        .SPI_LAT   (SPI_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .to_spi   (to_spi),
        .from_spi (from_spi),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_cmp(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic exp_burst(input byte_q_t pay);
        exp_q.push_back(8'(pay.size() + 1 + HDR));
        exp_q.push_back(8'd63);
        if (HDR != 0) begin
            exp_q.push_back(exp_seq);
            exp_seq = exp_seq + 8'd1;
        end
        foreach (pay[i]) exp_q.push_back(pay[i]);
    endtask

    task automatic stage(input int n, input logic [7:0] base, output byte_q_t q);
        q = {};
        for (int i = 0; i < n; i++) begin
            q.push_back(base + 8'(i));
            src_q.push_back(base + 8'(i));
        end
        for (int t = 0; t < 400 && src_q.size() != 0; t++) @(posedge clk);
        check("stage_accepted", 32'(src_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input int max_cyc);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_frame) && t < max_cyc) begin
            @(posedge clk);
            t++;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_seq = 8'd0;
    endtask

    // Input driver: presents src_q bytes, holding in_valid while any remain.
    initial begin
        in_valid = 1'b0;
        in_data  = 8'd0;
        forever begin
            @(posedge clk);
            if (in_valid && in_ready) void'(src_q.pop_front());
            #1;
            in_valid = (src_q.size() != 0);
            in_data  = (src_q.size() != 0) ? src_q[0] : 8'd0;
        end
    end

    // Stage-count model, stepped on every clock edge.
    initial begin
        cyc     = 0;
        mdl_cnt = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) mdl_cnt = 0;
            else mdl_cnt = mdl_cnt + int'(in_valid && in_ready) - int'(pop_pend);
        end
    end

    // Wire monitor: decodes framed transfers and checks burst bytes against exp_q.
    initial begin
        in_frame  = 1'b0;
        pop_pend  = 1'b0;
        f_is_poll = 1'b0;
        f_len     = 0;
        f_idx     = 0;
        f_first   = 8'd0;
        f_start   = 0;
        poll_cnt  = 0;
        data_seen = 0;
        forever begin
            @(negedge clk);
            pop_pend = 1'b0;
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                check("in_ready_vs_count", in_ready, 32'(mdl_cnt < MAX_BURST));
                if (!in_frame) begin
                    if (to_spi != 8'd0) begin
                        in_frame  = 1'b1;
                        f_len     = int'(to_spi);
                        f_first   = to_spi;
                        f_idx     = 1;
                        f_start   = cyc;
                        data_seen = 0;
                    end
                end else begin
                    if (f_idx == 1) begin
                        f_is_poll = (f_first == 8'd2) && (to_spi == 8'd3);
                        if (f_is_poll) begin
                            poll_start_cyc = f_start;
                        end else begin
                            burst_start_cyc = f_start;
                            sb_cmp("burst_len", f_first);
                            sb_cmp("burst_cmd", to_spi);
                        end
                    end else if (f_is_poll) begin
                        check("poll_dummy", to_spi, 8'd0);
                    end else begin
                        sb_cmp("burst_data", to_spi);
                        check("busy_in_data", busy, 1'b1);
                        data_seen++;
                        if (f_idx >= 2 + HDR) pop_pend = 1'b1;
                    end
                    if (f_idx == f_len) begin
                        in_frame = 1'b0;
                        if (f_is_poll) poll_cnt++;
                    end
                    f_idx++;
                end
            end
        end
    end

    initial begin
        byte_q_t q, q2;
        int      en_cyc;
        int      p0;
        int      t;

        n_tests  = 0;
        n_fail   = 0;
        exp_seq  = 8'd0;
        rst      = 1'b1;
        en       = 1'b0;
        from_spi = 8'd0;

        // Reset state
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_to_spi", to_spi, 8'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        // 10 bytes, usage 0: exact framing and timing
        stage(10, 8'h10, q);
        check("no_poll_while_disabled", busy, 1'b0);
        exp_burst(q);
        en     = 1'b1;
        en_cyc = cyc;
        wait_sb(200);
        check("en_to_poll", 32'(poll_start_cyc - en_cyc), 32'd1);
        check("poll_to_burst", 32'(burst_start_cyc - poll_start_cyc), 32'(SPI_LAT + 4));
        @(negedge clk);
        check("idle_to_spi", to_spi, 8'd0);
        check("busy_falls", busy, 1'b0);

        // 100 bytes with in_valid held: full burst then remainder
        en = 1'b0;
        q  = {};
        for (int i = 0; i < 100; i++) begin
            q.push_back(8'(i + 1));
            src_q.push_back(8'(i + 1));
        end
        t = 0;
        while (in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("fifo_full_deasserts_ready", in_ready, 1'b0);
        q2 = q[0:MAX_BURST-HDR-1];
        exp_burst(q2);
        q2 = q[MAX_BURST-HDR:99];
        exp_burst(q2);
        @(posedge clk);
        #1 en = 1'b1;
        wait_sb(400);
        check("all_100_accepted", 32'(src_q.size()), 32'd0);

        // Usage 250 limits the burst, then usage 255 gives no burst
        en       = 1'b0;
        from_spi = 8'd250;
        stage(20, 8'hA0, q);
        q2 = q[0:4-HDR];
        exp_burst(q2);
        en = 1'b1;
        wait_sb(200);
        from_spi = 8'd255;
        p0 = poll_cnt;
        t  = 0;
        while (poll_cnt < p0 + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("repoll_when_full", 32'(poll_cnt >= p0 + 2), 32'd1);
        #1 en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("full_buffer_idle", busy, 1'b0);
        check("full_buffer_no_burst", 32'(exp_q.size()), 32'd0);
        from_spi = 8'd0;
        q2 = q[5-HDR:19];
        exp_burst(q2);
        @(posedge clk);
        #1 en = 1'b1;
        wait_sb(200);

        // Reset during the 30th DATA cycle of a 64-byte burst
        en = 1'b0;
        stage(64, 8'h30, q);
        check("staged_64_full", in_ready, 1'b0);
        q2 = q[0:MAX_BURST-HDR-1];
        exp_burst(q2);
        data_seen = 0;
        en = 1'b1;
        t  = 0;
        while (data_seen < 29 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("reached_data_29", 32'(data_seen), 32'd29);
        #1 rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset_to_spi", to_spi, 8'd0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_unsent", 32'(exp_q.size()), 32'd35);
        exp_q.delete();
        exp_seq = 8'd0;
        p0 = poll_cnt;
        stage(3, 8'hC0, q);
        exp_burst(q);
        en = 1'b1;
        wait_sb(200);
        check("restart_single_poll", 32'(poll_cnt), 32'(p0 + 1));

        // Three 4-byte bursts after reset (sequence byte when enabled)
        en = 1'b0;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            en = 1'b0;
            stage(4, 8'(8'hE0 + 8'(b * 16)), q);
            exp_burst(q);
            en = 1'b1;
            wait_sb(200);
        end
        en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
